imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Single-port instruction-memory arbiter shared between the fetch stage and the program loader. It grants the memory to one requester per cycle and drives the synchronous memory port. It returns read data with a fixed one-cycle latency and asserts StallF so fetch holds its PC while the loader owns the memory. It sits between the fetch stage's PC/instruction-memory path and the instruction memory macro.

## Interface
- ADDR_W, 32, byte address width of all address ports
- DATA_W, 32, instruction/data word width
- MAX_LOAD_BURST, 8, max consecutive loader grants while f_req is pending (fairness build only); legal 1..255

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request, held until served
- f_addr  in  ADDR_W  fetch address (PCF)
- f_rdata  out  DATA_W  fetch read data, valid when f_valid
- f_valid  out  1  fetch read data valid
- StallF  out  1  fetch must hold PC this cycle
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_W  loader address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rdata  out  DATA_W  loader read data, valid when l_valid
- l_valid  out  1  loader read data valid
- m_en, m_we  out  1  memory enable / write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, one cycle after m_en & ~m_we

## Operation
- Owner FSM: IDLE (no read issued last cycle), F_RD (fetch read issued last cycle), L_RD (loader read issued last cycle). Next state is decided by the current cycle's grant: a fetch grant goes to F_RD; a loader read goes to L_RD; a loader write or no grant goes to IDLE.
- Arbitration (combinational, same cycle):
  - l_req=1 wins, except when the fairness override is active (see Configuration).
  - Otherwise f_req=1 wins.
  - Otherwise no access: m_en=0.
- Fetch grant: m_en=1, m_we=0, m_addr=f_addr.
- Loader grant: l_gnt=1, m_en=1, m_we=l_we, m_addr=l_addr, m_wdata=l_wdata.
- StallF = f_req & ~fetch_grant.
- f_valid=1 in the cycle after a fetch grant. f_rdata=m_rdata when f_valid, else 0.
- l_valid=1 in the cycle after a loader read grant. l_rdata=m_rdata when l_valid, else 0.
- Loader writes return no response.
- m_wdata=0 when the loader is not granted.
- Accesses are strictly serialised, so a write in cycle N is visible to any read granted in cycle N+1 or later. No forwarding.
- Boundary cases:
  - f_req and l_req dropping together: the FSM goes to IDLE with no access.
  - Back-to-back grants to alternating requesters are legal every cycle.

## Timing
- Arbitration latency is 0 cycles (grant in the request cycle). Read latency is 1 cycle.
- Fetch throughput is 1 word/cycle while l_req=0.
- Reset values: FSM=IDLE, fairness counter=0, f_valid=l_valid=0, f_rdata=l_rdata=0. With no requests, StallF=0, l_gnt=0, m_en=m_we=0, m_addr=0, m_wdata=0.
- Reset asserted while a read is outstanding: the pending response is discarded. No valid is asserted after reset release.

## Configuration
- IMEM_ARB_FAIRNESS_EN **defined**:
  - An 8-bit counter counts consecutive loader grants made while f_req=1.
  - When the count reaches MAX_LOAD_BURST, the next cycle with f_req=1 grants fetch even if l_req=1. The counter then clears to 0.
  - The counter also clears on any fetch grant, or on any cycle with f_req=0.
- IMEM_ARB_FAIRNESS_EN **undefined**: strict loader priority. No counter is built. Fetch can stall indefinitely while l_req=1.

## Test plan
- Reset check: rst=1 with random inputs, then released -> f_valid=l_valid=0 and FSM=IDLE; with f_req=l_req=0 also StallF=0, m_en=0.
- Fetch only: f_req=1 with f_addr=0x00, 0x04, 0x08 on consecutive cycles and memory preloaded with 0x00500093, 0x00A00113, 0x002081B3 -> StallF=0 throughout; f_valid=1 with those words in cycles 1, 2, 3.
- Loader preemption: f_req=1 and loader writes 0xDEADBEEF to 0x10 in cycle 0 -> l_gnt=1, StallF=1, m_we=1 in cycle 0. Fetch read of 0x10 in cycle 1 returns 0xDEADBEEF in cycle 2.
- Loader read: l_req=1, l_we=0, l_addr=0x04 -> l_valid=1, l_rdata=0x00A00113 one cycle later; f_valid stays 0.
- Fairness (macro defined, MAX_LOAD_BURST=8): l_req and f_req held high for 20 cycles -> 8 loader grants, 1 fetch grant, repeating; StallF=0 in cycles 8 and 17. Macro undefined: StallF=1 for all 20 cycles.
- Reset mid-read: assert rst in the cycle after a fetch grant -> f_valid=0 and no stale data after release.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction-memory arbiter shared by the fetch
// stage and the program loader. Grants one requester per cycle, drives the
// synchronous memory port and returns read data one cycle after the grant.
// Build option: define IMEM_ARB_FAIRNESS_EN to bound the number of
// consecutive loader grants while fetch is waiting (MAX_LOAD_BURST).
module imem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_LOAD_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_valid,
    output logic              StallF,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_valid,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    // State records which requester (if any) has a read in flight.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        F_RD = 2'd1,
        L_RD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   fetch_grant;
    logic   load_grant;
    logic   fair_override;

`ifdef IMEM_ARB_FAIRNESS_EN
    logic [7:0] burst_cnt;

    // Fetch takes the port once the loader has used up its burst allowance.
    always_comb begin
        fair_override = f_req && (burst_cnt >= 8'(MAX_LOAD_BURST));
    end

    // Count consecutive loader grants made while fetch is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (!f_req || fetch_grant) begin
            burst_cnt <= '0;
        end else if (load_grant) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`else
    logic unused_burst_cfg;

    // Strict loader priority: no override, burst limit has no effect.
    always_comb begin
        fair_override    = 1'b0;
        unused_burst_cfg = |8'(MAX_LOAD_BURST);
    end
`endif

    // Same-cycle arbitration and memory port drive.
    always_comb begin
        load_grant  = l_req && !fair_override;
        fetch_grant = f_req && !load_grant;
        l_gnt       = load_grant;
        StallF      = f_req && !fetch_grant;
        m_en        = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        if (load_grant) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end else if (fetch_grant) begin
            m_en   = 1'b1;
            m_addr = f_addr;
        end
    end

    // Next owner follows this cycle's grant; writes return nothing.
    always_comb begin
        state_nxt = IDLE;
        if (load_grant && !l_we) begin
            state_nxt = L_RD;
        end else if (fetch_grant) begin
            state_nxt = F_RD;
        end
    end

    // Owner state register; reset discards any outstanding response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Route returning read data to whoever issued last cycle's read.
    always_comb begin
        f_valid = (state == F_RD);
        l_valid = (state == L_RD);
        f_rdata = f_valid ? m_rdata : '0;
        l_rdata = l_valid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter with a synchronous
// memory model and a behavioural reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_rdata;
    logic          f_valid;
    logic          StallF;
    logic          l_req = 1'b0;
    logic          l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          l_gnt;
    logic [DW-1:0] l_rdata;
    logic          l_valid;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    int checks   = 0;
    int failures = 0;

    imem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_LOAD_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_valid(f_valid),
        .StallF(StallF),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rdata(l_rdata), .l_valid(l_valid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory macro, word indexed.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr[7:2]] <= m_wdata;
            else      m_rdata <= mem[m_addr[7:2]];
        end
    end

    task automatic drive_idle();
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic idle_cycle();
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            f_req = 1'($urandom); f_addr = $urandom;
            l_req = 1'($urandom); l_we = 1'($urandom);
            l_addr = $urandom; l_wdata = $urandom;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({f_valid, l_valid} !== 2'b00) begin
            failures++; $display("FAIL reset_valid_during_rst got=%b exp=00", {f_valid, l_valid});
        end
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({f_valid, l_valid, StallF, l_gnt, m_en, m_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {f_valid, l_valid, StallF, l_gnt, m_en, m_we});
        end
        checks++;
        if ({m_addr, m_wdata, f_rdata, l_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_buses got=%h/%h/%h/%h exp=0", m_addr, m_wdata, f_rdata, l_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        logic [DW-1:0] prog [3];
        logic [DW-1:0] w;
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113; prog[2] = 32'h002081B3;
        idle_cycle();
        for (int i = 0; i < 64; i++) begin
            w = (i < 3) ? prog[i] : $urandom;
            l_req = 1'b1; l_we = 1'b1; l_addr = AW'(i * 4); l_wdata = w;
            ref_mem[i] = w;
            @(negedge clk);
            checks++;
            if ({l_gnt, m_en, m_we, l_valid} !== 4'b1110) begin
                failures++; $display("FAIL preload_write[%0d] got=%b exp=1110", i, {l_gnt, m_en, m_we, l_valid});
            end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_fetch_only();
        idle_cycle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                f_req = 1'b1; f_addr = AW'(i * 4);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            checks++;
            if (StallF !== 1'b0) begin
                failures++; $display("FAIL fetch_stall[%0d] got=%b exp=0", i, StallF);
            end
            if (i < 3) begin
                checks++;
                if ({m_en, m_we, m_addr} !== {2'b10, AW'(i * 4)}) begin
                    failures++; $display("FAIL fetch_port[%0d] got=%b%b/%h exp=10/%h", i, m_en, m_we, m_addr, i * 4);
                end
            end
            checks++;
            if (i == 0) begin
                if (f_valid !== 1'b0) begin
                    failures++; $display("FAIL fetch_valid0 got=%b exp=0", f_valid);
                end
            end else if ({f_valid, f_rdata} !== {1'b1, ref_mem[i-1]}) begin
                failures++; $display("FAIL fetch_data[%0d] got=%b/%h exp=1/%h", i, f_valid, f_rdata, ref_mem[i-1]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_preempt();
        idle_cycle();
        f_req = 1'b1; f_addr = 32'h10;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({l_gnt, StallF, m_we, m_addr, m_wdata} !== {3'b111, 32'h10, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL preempt_grant got=%b%b%b/%h/%h exp=111/10/deadbeef", l_gnt, StallF, m_we, m_addr, m_wdata);
        end
        ref_mem[4] = 32'hDEADBEEF;
        @(posedge clk); #1;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        @(negedge clk);
        checks++;
        if ({StallF, l_gnt, m_en, l_valid, f_valid} !== 5'b00100) begin
            failures++; $display("FAIL preempt_fetch got=%b exp=00100", {StallF, l_gnt, m_en, l_valid, f_valid});
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({f_valid, f_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            failures++; $display("FAIL preempt_readback got=%b/%h exp=1/deadbeef", f_valid, f_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loader_read();
        idle_cycle();
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h04;
        @(negedge clk);
        checks++;
        if ({l_gnt, m_en, m_we} !== 3'b110) begin
            failures++; $display("FAIL lread_grant got=%b exp=110", {l_gnt, m_en, m_we});
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({l_valid, l_rdata, f_valid, f_rdata} !== {1'b1, 32'h00A00113, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL lread_data got=%b/%h f=%b/%h exp=1/00a00113 f=0/0", l_valid, l_rdata, f_valid, f_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic exp_fetch;
        idle_cycle();
        for (int i = 0; i < 20; i++) begin
            f_req = 1'b1; f_addr = 32'h0;
            l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
`ifdef IMEM_ARB_FAIRNESS_EN
            exp_fetch = ((i % (MAXB + 1)) == MAXB);
`else
            exp_fetch = 1'b0;
`endif
            @(negedge clk);
            checks++;
            if ({StallF, l_gnt} !== {!exp_fetch, !exp_fetch}) begin
                failures++;
                $display("FAIL fairness[%0d] got stall=%b gnt=%b exp stall=%b gnt=%b", i, StallF, l_gnt, !exp_fetch, !exp_fetch);
            end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        idle_cycle();
        f_req = 1'b1; f_addr = 32'h8;
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({f_valid, f_rdata} !== {1'b0, 32'h0}) begin
            failures++; $display("FAIL rst_mid_read got=%b/%h exp=0/0", f_valid, f_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({f_valid, l_valid, f_rdata, l_rdata} !== '0) begin
            failures++; $display("FAIL rst_after_release got=%b%b/%h/%h exp=00/0/0", f_valid, l_valid, f_rdata, l_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int            burst = 0;
        bit            pf = 0, pl = 0, hold = 0;
        bit            ovr, efg, elg;
        logic [DW-1:0] pfd = '0, pld = '0;
        logic [AW-1:0] eaddr;
        idle_cycle();
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            end
            l_req   = ($urandom_range(0, 2) == 0);
            l_we    = 1'($urandom);
            l_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            l_wdata = $urandom;
            ovr = 1'b0;
`ifdef IMEM_ARB_FAIRNESS_EN
            ovr = f_req && (burst >= int'(MAXB));
`endif
            elg = l_req && !ovr;
            efg = f_req && !elg;
            eaddr = efg ? f_addr : (elg ? l_addr : '0);
            @(negedge clk);
            checks++;
            if ({l_gnt, StallF, m_en, m_we} !== {elg, f_req && !efg, efg || elg, elg && l_we}) begin
                failures++;
                $display("FAIL rand_ctrl[%0d] got=%b exp=%b", n, {l_gnt, StallF, m_en, m_we},
                         {elg, f_req && !efg, efg || elg, elg && l_we});
            end
            checks++;
            if ({m_addr, m_wdata} !== {eaddr, elg ? l_wdata : 32'h0}) begin
                failures++;
                $display("FAIL rand_port[%0d] got=%h/%h exp=%h/%h", n, m_addr, m_wdata, eaddr, elg ? l_wdata : 32'h0);
            end
            checks++;
            if ({f_valid, f_rdata} !== {pf, pf ? pfd : 32'h0}) begin
                failures++; $display("FAIL rand_fresp[%0d] got=%b/%h exp=%b/%h", n, f_valid, f_rdata, pf, pf ? pfd : 32'h0);
            end
            checks++;
            if ({l_valid, l_rdata} !== {pl, pl ? pld : 32'h0}) begin
                failures++; $display("FAIL rand_lresp[%0d] got=%b/%h exp=%b/%h", n, l_valid, l_rdata, pl, pl ? pld : 32'h0);
            end
            pf  = efg;
            pfd = ref_mem[f_addr[7:2]];
            pl  = elg && !l_we;
            pld = ref_mem[l_addr[7:2]];
            if (elg && l_we) ref_mem[l_addr[7:2]] = l_wdata;
            if (!f_req || efg) burst = 0;
            else if (elg)      burst++;
            hold = f_req && !efg;
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_fetch_only();
        test_preempt();
        test_loader_read();
        test_fairness();
        test_reset_mid_read();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
